mining_core: RTL and testbench

Self-contained proof-of-work mining block. It contains:
- a 512-bit-row block RAM, filled with 32-bit message words;
- a control FSM;
- an iterative SHA-256 compression core.

Once loading is done, the block reads one 512-bit row and inserts a 32-bit nonce into it. It then hashes the row repeatedly, incrementing the nonce each time, until the digest has DIFFICULTY leading zero bits. It sits between a host/bench that streams words in and logic that consumes HASH/NONCE_OUT.

---
 rtl/mining_core.sv | 221 ++++++++++++++++++++++
 tb/tb_mining_core.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mining_core.sv
// rtl/mining_core.sv - proof-of-work miner: row RAM, control FSM and iterative SHA-256 core
// Optional feature macro DOUBLE_SHA_EN: every first digest is hashed again and the second digest is tested.
module mining_core #(
    parameter int DEPTH      = 16,
    parameter int DIFFICULTY = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stopw,
    input  logic [31:0]  message,
    input  logic [15:0]  indirizzo,
    input  logic [8:0]   indirizzo_width,
    input  logic [15:0]  indirizzo_nonce,
    input  logic [8:0]   nonce_width,
    output logic [255:0] HASH,
    output logic [31:0]  NONCE_OUT,
    output logic [2:0]   state,
    output logic         found
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [255:0] DMASK = ~({256{1'b1}} >> DIFFICULTY);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        S_WRITE = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_HASH  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t         st;
    logic [511:0]   mem [DEPTH];
    logic [511:0]   blk;
    logic [511:0]   chunk;
    logic [511:0]   sched_src;
    logic [31:0]    nonce;
    logic [31:0]    w [16];
    logic [31:0]    hv [8];
    logic [5:0]     rnd;
    logic [31:0]    ch, maj, t1, t2, w_next;
    logic [255:0]   digest;
    logic [AW-1:0]  wr_row, rd_row;
    logic           wr_en;

`ifdef DOUBLE_SHA_EN
    logic           pass2;
    logic [1:0]     gap;
    logic [255:0]   d1;
    logic           in_gap, last_round;
    assign in_gap     = (gap != 2'd0);
    assign last_round = pass2 && !in_gap && (rnd == 6'd63);
`else
    logic           in_gap, last_round;
    assign in_gap     = 1'b0;
    assign last_round = (rnd == 6'd63);
`endif

    assign wr_row = AW'(indirizzo % 16'(DEPTH));
    assign rd_row = AW'(indirizzo_nonce % 16'(DEPTH));
    assign wr_en  = (st == S_WRITE) && !stopw && (indirizzo_width >= 9'd31);
    assign state  = st;

    // RAM has no reset so rows survive an aborted run
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_row][indirizzo_width -: 32] <= message;
        if (st == S_READ)
            blk <= mem[rd_row];
    end

    always_comb begin
        chunk = blk;
        if (nonce_width >= 9'd31)
            chunk[nonce_width -: 32] = nonce;
`ifdef DOUBLE_SHA_EN
        sched_src = (st == S_HASH) ? {d1, 32'h8000_0000, 192'd0, 32'h0000_0100} : chunk;
`else
        sched_src = chunk;
`endif
    end

    always_comb begin
        ch     = (hv[4] & hv[5]) ^ (~hv[4] & hv[6]);
        maj    = (hv[0] & hv[1]) ^ (hv[0] & hv[2]) ^ (hv[1] & hv[2]);
        t1     = hv[7] + bsig1(hv[4]) + ch + K[rnd] + w[0];
        t2     = bsig0(hv[0]) + maj;
        w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        digest = '0;
        for (int i = 0; i < 8; i++)
            digest[255 - 32*i -: 32] = IV[i] + hv[i];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st        <= S_WRITE;
            HASH      <= '0;
            NONCE_OUT <= '0;
            found     <= 1'b0;
            nonce     <= '0;
            rnd       <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) hv[i] <= '0;
`ifdef DOUBLE_SHA_EN
            pass2     <= 1'b0;
            gap       <= 2'd0;
            d1        <= '0;
`endif
        end else begin
            case (st)
                S_WRITE: begin
                    if (stopw)
                        st <= S_READ;
                end
                S_READ: begin
                    nonce <= '0;
                    st    <= S_LOAD;
                end
                S_LOAD: begin
                    for (int i = 0; i < 16; i++) w[i] <= sched_src[511 - 32*i -: 32];
                    for (int i = 0; i < 8; i++) hv[i] <= IV[i];
                    rnd <= '0;
`ifdef DOUBLE_SHA_EN
                    pass2 <= 1'b0;
                    gap   <= 2'd0;
`endif
                    st  <= S_HASH;
                end
                S_HASH: begin
                    if (!in_gap) begin
                        for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                        w[15] <= w_next;
                        hv[0] <= t1 + t2;
                        hv[1] <= hv[0];
                        hv[2] <= hv[1];
                        hv[3] <= hv[2];
                        hv[4] <= hv[3] + t1;
                        hv[5] <= hv[4];
                        hv[6] <= hv[5];
                        hv[7] <= hv[6];
                        rnd   <= rnd + 6'd1;
                    end
`ifdef DOUBLE_SHA_EN
                    // two bubble cycles: latch the first digest, then restart on its padded form
                    if (gap == 2'd1) begin
                        d1  <= digest;
                        gap <= 2'd2;
                    end else if (gap == 2'd2) begin
                        for (int i = 0; i < 16; i++) w[i] <= sched_src[511 - 32*i -: 32];
                        for (int i = 0; i < 8; i++) hv[i] <= IV[i];
                        rnd   <= '0;
                        pass2 <= 1'b1;
                        gap   <= 2'd0;
                    end else if (rnd == 6'd63 && !pass2) begin
                        gap <= 2'd1;
                    end
`endif
                    if (last_round)
                        st <= S_CHECK;
                end
                S_CHECK: begin
                    HASH      <= digest;
                    NONCE_OUT <= nonce;
                    if ((digest & DMASK) == '0) begin
                        found <= 1'b1;
                        st    <= S_DONE;
                    end else if (nonce == '1) begin
                        found <= 1'b0;
                        st    <= S_DONE;
                    end else begin
                        nonce <= nonce + 32'd1;
                        st    <= S_LOAD;
                    end
                end
                S_DONE: begin
                    st <= S_DONE;
                end
                default: st <= S_WRITE;
            endcase
        end
    end

endmodule

// File: tb/tb_mining_core.sv
// tb/tb_mining_core.sv - randomized self-checking bench for mining_core against a SHA-256 reference model
module tb_mining_core;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         stopw = 1'b0;
    logic [31:0]  message = '0;
    logic [15:0]  indirizzo = '0;
    logic [15:0]  indirizzo_nonce = '0;
    logic [8:0]   indirizzo_width = '0;
    logic [8:0]   nonce_width = '0;
    logic [255:0] h0, h8;
    logic [31:0]  n0, n8;
    logic [2:0]   s0, s8;
    logic         f0, f8;

    int           vectors = 0;
    int           miscompares = 0;
    logic [511:0] ram [16];
    int           d_row, d_n;
    logic [8:0]   d_nw;
    logic [255:0] d_hash, d_hash0;

    always #5 clock = ~clock;

    mining_core #(.DEPTH(16), .DIFFICULTY(0)) dut0 (
        .clock(clock), .reset(reset), .stopw(stopw), .message(message),
        .indirizzo(indirizzo), .indirizzo_width(indirizzo_width),
        .indirizzo_nonce(indirizzo_nonce), .nonce_width(nonce_width),
        .HASH(h0), .NONCE_OUT(n0), .state(s0), .found(f0)
    );

    mining_core #(.DEPTH(16), .DIFFICULTY(8)) dut8 (
        .clock(clock), .reset(reset), .stopw(stopw), .message(message),
        .indirizzo(indirizzo), .indirizzo_width(indirizzo_width),
        .indirizzo_nonce(indirizzo_nonce), .nonce_width(nonce_width),
        .HASH(h8), .NONCE_OUT(n8), .state(s8), .found(f8)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression with the full 64-entry message schedule
    function automatic logic [255:0] sha256(input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  a, b, c, d, e, f, g, h, t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        a = IV[0]; b = IV[1]; c = IV[2]; d = IV[3];
        e = IV[4]; f = IV[5]; g = IV[6]; h = IV[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        res = {IV[0] + a, IV[1] + b, IV[2] + c, IV[3] + d, IV[4] + e, IV[5] + f, IV[6] + g, IV[7] + h};
        return res;
    endfunction

    function automatic logic [511:0] ins(input logic [511:0] b, input logic [8:0] nw, input logic [31:0] n);
        logic [511:0] r;
        r = b;
        if (nw >= 9'd31) r[nw -: 32] = n;
        return r;
    endfunction

    function automatic int find_nonce(input logic [511:0] b, input logic [8:0] nw, input int lim,
                                      output logic [255:0] hsh);
        hsh = '0;
        for (int n = 0; n < lim; n++) begin
            hsh = sha256(ins(b, nw, 32'(n)));
            if (hsh[255:248] == 8'h00) return n;
        end
        return -1;
    endfunction

    task automatic wr(input logic [15:0] row, input logic [8:0] wd, input logic [31:0] data);
        logic [511:0] r;
        @(negedge clock);
        indirizzo = row; indirizzo_width = wd; message = data; stopw = 1'b0;
        if (wd >= 9'd31) begin
            r = ram[row[3:0]];
            r[wd -: 32] = data;
            ram[row[3:0]] = r;
        end
        @(negedge clock);
        indirizzo_width = 9'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        stopw = 1'b0; indirizzo_width = 9'd0; reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Returns clock edges from the READ entry until the chosen instance shows DONE, or -1 on timeout
    task automatic mine(input logic [15:0] row, input logic [8:0] nw, input bit use8, output int cyc);
        @(negedge clock);
        indirizzo_nonce = row; nonce_width = nw; stopw = 1'b1;
        @(negedge clock);
        cyc = -1;
        for (int i = 1; i <= 30000; i++) begin
            @(negedge clock);
            if ((use8 ? s8 : s0) == 3'd5) begin
                cyc = i;
                break;
            end
        end
        stopw = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            stopw = 1'($urandom); message = $urandom; indirizzo = 16'($urandom);
            indirizzo_width = 9'($urandom); indirizzo_nonce = 16'($urandom); nonce_width = 9'($urandom);
        end
        #1;
        vectors++; if (s0 !== 3'd0 || s8 !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d/%0d want 0", s0, s8); end
        vectors++; if (h0 !== '0 || h8 !== '0) begin miscompares++; $display("FAIL reset_hash: got %h/%h want 0", h0, h8); end
        vectors++; if (n0 !== '0 || n8 !== '0) begin miscompares++; $display("FAIL reset_nonce: got %h/%h want 0", n0, n8); end
        vectors++; if (f0 !== 1'b0 || f8 !== 1'b0) begin miscompares++; $display("FAIL reset_found: got %b/%b want 0", f0, f8); end
        @(negedge clock);
        stopw = 1'b0; indirizzo_width = 9'd0; reset = 1'b1;
        repeat (5) @(negedge clock);
        vectors++; if (s0 !== 3'd0 || s8 !== 3'd0) begin miscompares++; $display("FAIL idle_write: got %0d/%0d want 0", s0, s8); end
    endtask

    task automatic test_abc();
        int cyc;
        do_reset();
        for (int i = 0; i < 16; i++)
            wr(16'd0, 9'(511 - 32*i), (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0));
        mine(16'd0, 9'd63, 1'b0, cyc);
        vectors++; if (cyc !== 67) begin miscompares++; $display("FAIL abc_cycles: got %0d want 67", cyc); end
        vectors++; if (h0 !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
            miscompares++; $display("FAIL abc_hash: got %h want ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad", h0); end
        vectors++; if (n0 !== 32'd0) begin miscompares++; $display("FAIL abc_nonce: got %h want 0", n0); end
        vectors++; if (f0 !== 1'b1) begin miscompares++; $display("FAIL abc_found: got %b want 1", f0); end
        vectors++; if (s0 !== 3'd5) begin miscompares++; $display("FAIL abc_state: got %0d want 5", s0); end
    endtask

    task automatic test_partial_writes();
        logic [255:0] exp;
        logic [8:0]   nw;
        int           cyc;
        do_reset();
        for (int i = 0; i < 16; i++) wr(16'd1, 9'(511 - 32*i), $urandom);
        wr(16'd1, 9'd15, $urandom);
        wr(16'd1, 9'd30, $urandom);
        wr(16'd17, 9'd511, $urandom);
        wr(16'd1, 9'd31, $urandom);
        wr(16'd1, 9'($urandom_range(32, 510)), $urandom);
        nw  = 9'($urandom_range(31, 511));
        exp = sha256(ins(ram[1], nw, 32'd0));
        mine(16'd17, nw, 1'b0, cyc);
        vectors++; if (cyc !== 67) begin miscompares++; $display("FAIL partial_cycles: got %0d want 67", cyc); end
        vectors++; if (h0 !== exp) begin miscompares++; $display("FAIL partial_hash: got %h want %h", h0, exp); end
        vectors++; if (f0 !== 1'b1) begin miscompares++; $display("FAIL partial_found: got %b want 1", f0); end
        do_reset();
        exp = sha256(ram[1]);
        mine(16'd1, 9'd15, 1'b0, cyc);
        vectors++; if (h0 !== exp) begin miscompares++; $display("FAIL no_insert_hash: got %h want %h", h0, exp); end
        vectors++; if (n0 !== 32'd0) begin miscompares++; $display("FAIL no_insert_nonce: got %h want 0", n0); end
    endtask

    task automatic test_difficulty();
        logic [511:0] cand;
        logic [255:0] hh;
        logic [15:0]  addr;
        int           n, cyc;
        n = -1;
        cand = '0;
        hh = '0;
        for (int tries = 0; tries < 60 && n < 2; tries++) begin
            for (int i = 0; i < 16; i++) cand[511 - 32*i -: 32] = $urandom;
            d_nw = 9'($urandom_range(31, 511));
            n = find_nonce(cand, d_nw, 300, hh);
        end
        d_n     = n;
        d_hash  = hh;
        d_hash0 = sha256(ins(cand, d_nw, 32'd0));
        d_row   = $urandom_range(2, 15);
        do_reset();
        addr = 16'(d_row + 16 * $urandom_range(0, 4000));
        for (int i = 0; i < 16; i++) wr(addr, 9'(511 - 32*i), cand[511 - 32*i -: 32]);
        mine(16'(d_row), d_nw, 1'b1, cyc);
        vectors++; if (cyc !== 1 + 66 * (d_n + 1)) begin miscompares++; $display("FAIL diff_cycles: got %0d want %0d", cyc, 1 + 66 * (d_n + 1)); end
        vectors++; if (n8 !== 32'(d_n)) begin miscompares++; $display("FAIL diff_nonce: got %0d want %0d", n8, d_n); end
        vectors++; if (h8 !== d_hash) begin miscompares++; $display("FAIL diff_hash: got %h want %h", h8, d_hash); end
        vectors++; if (f8 !== 1'b1) begin miscompares++; $display("FAIL diff_found: got %b want 1", f8); end
        vectors++; if (h0 !== d_hash0) begin miscompares++; $display("FAIL diff0_hash: got %h want %h", h0, d_hash0); end
        vectors++; if (n0 !== 32'd0 || f0 !== 1'b1) begin miscompares++; $display("FAIL diff0_nonce_found: got %h/%b want 0/1", n0, f0); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        @(negedge clock);
        indirizzo_nonce = 16'(d_row); nonce_width = d_nw; stopw = 1'b1;
        @(negedge clock);
        repeat (96) @(negedge clock);
        vectors++; if (s8 !== 3'd3 || s0 !== 3'd5) begin miscompares++; $display("FAIL mid_state: got %0d/%0d want 5/3", s0, s8); end
        reset = 1'b0;
        #1;
        vectors++; if (s0 !== 3'd0 || s8 !== 3'd0) begin miscompares++; $display("FAIL abort_state: got %0d/%0d want 0", s0, s8); end
        vectors++; if (h0 !== '0 || h8 !== '0) begin miscompares++; $display("FAIL abort_hash: got %h/%h want 0", h0, h8); end
        vectors++; if (n0 !== '0 || n8 !== '0 || f0 !== 1'b0 || f8 !== 1'b0) begin
            miscompares++; $display("FAIL abort_nonce_found: got %h/%h %b/%b want 0", n0, n8, f0, f8); end
        @(negedge clock);
        stopw = 1'b0; reset = 1'b1;
        mine(16'(d_row), d_nw, 1'b1, cyc);
        vectors++; if (cyc !== 1 + 66 * (d_n + 1)) begin miscompares++; $display("FAIL remine_cycles: got %0d want %0d", cyc, 1 + 66 * (d_n + 1)); end
        vectors++; if (n8 !== 32'(d_n)) begin miscompares++; $display("FAIL remine_nonce: got %0d want %0d", n8, d_n); end
        vectors++; if (h8 !== d_hash) begin miscompares++; $display("FAIL remine_hash: got %h want %h", h8, d_hash); end
    endtask

    task automatic test_done_hold();
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            vectors++; if (s8 !== 3'd5 || s0 !== 3'd5) begin miscompares++; $display("FAIL hold_state: got %0d/%0d want 5", s0, s8); end
            vectors++; if (h8 !== d_hash) begin miscompares++; $display("FAIL hold_hash: got %h want %h", h8, d_hash); end
            vectors++; if (n8 !== 32'(d_n) || f8 !== 1'b1) begin miscompares++; $display("FAIL hold_nonce_found: got %0d/%b want %0d/1", n8, f8, d_n); end
            vectors++; if (h0 !== d_hash0 || f0 !== 1'b1) begin miscompares++; $display("FAIL hold0_hash: got %h want %h", h0, d_hash0); end
            stopw = 1'($urandom); message = $urandom; indirizzo = 16'($urandom);
            indirizzo_width = 9'($urandom); indirizzo_nonce = 16'($urandom); nonce_width = 9'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_partial_writes();
        test_difficulty();
        test_reset_mid();
        test_done_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
